// File: rtl/ps2_port.sv
// PS/2 device-to-host receiver: synchronize + glitch-filter the lines, deframe 11-bit frames, fold E0/F0 prefixes in keyboard mode.
// Latency: 2 sync + FILTER_LEN + 1 cycles from clock-line edge to strobe; outputs update the cycle after the stop-bit strobe. No backpressure.
module ps2_port #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 262143
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_rcv,
    input  logic       kb_or_mouse,
    input  logic       ps2clk_ext,
    input  logic       ps2data_ext,
    output logic       kb_interrupt,
    output logic [7:0] scancode,
    output logic       released,
    output logic       extended
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          strobe;

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          pend_ext_q, pend_ext_d, pend_rel_q, pend_rel_d;
    logic [7:0]    sc_q, sc_d;
    logic          rel_q, rel_d, ext_q, ext_d, irq_q, irq_d;

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign strobe = filt_prev_q & ~filt_q;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tcnt_d     = tcnt_q;
        pend_ext_d = pend_ext_q;
        pend_rel_d = pend_rel_q;
        sc_d       = sc_q;
        rel_d      = rel_q;
        ext_d      = ext_q;
        irq_d      = 1'b0;
        if (!enable_rcv) begin
            state_d = IDLE;
            tcnt_d  = '0;
        end else if (strobe) begin
            tcnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (((^shift_q) ^ par_q) && dat_s2_q) begin
                        if (!kb_or_mouse && shift_q == 8'hE0) begin
                            pend_ext_d = 1'b1;
                        end else if (!kb_or_mouse && shift_q == 8'hF0) begin
                            pend_rel_d = 1'b1;
                        end else begin
                            sc_d       = shift_q;
                            ext_d      = pend_ext_q & ~kb_or_mouse;
                            rel_d      = pend_rel_q & ~kb_or_mouse;
                            irq_d      = 1'b1;
                            pend_ext_d = 1'b0;
                            pend_rel_d = 1'b0;
                        end
                    end else begin
                        pend_ext_d = 1'b0;
                        pend_rel_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
                state_d    = IDLE;
                tcnt_d     = '0;
                pend_ext_d = 1'b0;
                pend_rel_d = 1'b0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
        if (kb_or_mouse) begin
            pend_ext_d = 1'b0;
            pend_rel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tcnt_q      <= '0;
            pend_ext_q  <= 1'b0;
            pend_rel_q  <= 1'b0;
            sc_q        <= 8'h00;
            rel_q       <= 1'b0;
            ext_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            clk_s1_q    <= ps2clk_ext;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2data_ext;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tcnt_q      <= tcnt_d;
            pend_ext_q  <= pend_ext_d;
            pend_rel_q  <= pend_rel_d;
            sc_q        <= sc_d;
            rel_q       <= rel_d;
            ext_q       <= ext_d;
            irq_q       <= irq_d;
        end
    end

    assign kb_interrupt = irq_q;
    assign scancode     = sc_q;
    assign released     = rel_q;
    assign extended     = ext_q;
endmodule

// File: tb/tb_ps2_port.sv
// Directed bench for ps2_port: frame-level scancode model with per-cycle output compare plus literal spot checks.
module tb_ps2_port;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_rcv = 1'b1;
    logic       kb_or_mouse = 1'b0;
    logic       ps2clk_ext = 1'b1;
    logic       ps2data_ext = 1'b1;
    logic       kb_interrupt;
    logic [7:0] scancode;
    logic       released;
    logic       extended;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit chk_en = 1'b0;

    logic [9:0] exp_q[$];
    logic [9:0] hold = 10'h000;
    bit         pend_e = 1'b0;
    bit         pend_r = 1'b0;

    ps2_port #(.FILTER_LEN(8), .TIMEOUT_CYCLES(400)) dut (
        .clk(clk), .rst_n(rst_n), .enable_rcv(enable_rcv), .kb_or_mouse(kb_or_mouse),
        .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext), .kb_interrupt(kb_interrupt),
        .scancode(scancode), .released(released), .extended(extended)
    );

    always #5 clk = ~clk;

    // Compare process: every pulse must match the next expected delivery; otherwise outputs hold.
    always @(negedge clk) begin
        if (chk_en) begin
            if (kb_interrupt !== 1'b0) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: unexpected kb_interrupt=%b, scancode=%h", kb_interrupt, scancode);
                end else begin
                    hold = exp_q.pop_front();
                end
            end
            checks++;
            if ({scancode, released, extended} !== hold) begin
                errors++;
                $display("FAIL outputs: got sc=%h rel=%b ext=%b, want sc=%h rel=%b ext=%b",
                         scancode, released, extended, hold[9:2], hold[1], hold[0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            pend_e = 1'b0;
            pend_r = 1'b0;
        end else if (kb_or_mouse) begin
            exp_q.push_back({b, 2'b00});
        end else if (b == 8'hE0) begin
            pend_e = 1'b1;
        end else if (b == 8'hF0) begin
            pend_r = 1'b1;
        end else begin
            exp_q.push_back({b, pend_r, pend_e});
            pend_e = 1'b0;
            pend_r = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2data_ext = b;
        tick(HALF);
        ps2clk_ext = 1'b0;
        tick(HALF);
        ps2clk_ext = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2data_ext = 1'b1;
        tick(60);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par);
        model_byte(b, !bad_par);
        send_raw(b, bad_par);
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        tick(5);
        rst_n = 1'b1;
        tick(2);
        chk("reset_irq", kb_interrupt, 0);
        chk("reset_sc", scancode, 8'h00);
        chk("reset_flags", {released, extended}, 0);
        chk_en = 1'b1;

        p0 = pulses;
        frame(8'h1C, 1'b0);
        chk("make_pulses", pulses - p0, 1);
        chk("make_out", {scancode, released, extended}, {8'h1C, 2'b00});

        p0 = pulses;
        frame(8'hF0, 1'b0);
        frame(8'h1C, 1'b0);
        chk("break_pulses", pulses - p0, 1);
        chk("break_out", {scancode, released, extended}, {8'h1C, 2'b10});
        frame(8'h1C, 1'b0);
        chk("after_break", {scancode, released, extended}, {8'h1C, 2'b00});

        p0 = pulses;
        frame(8'hE0, 1'b0);
        frame(8'hF0, 1'b0);
        frame(8'h75, 1'b0);
        chk("ext_break_pulses", pulses - p0, 1);
        chk("ext_break_out", {scancode, released, extended}, {8'h75, 2'b11});

        p0 = pulses;
        frame(8'hF0, 1'b0);
        frame(8'h1C, 1'b1);
        chk("parity_nopulse", pulses - p0, 0);
        chk("parity_hold", scancode, 8'h75);
        frame(8'h32, 1'b0);
        chk("after_parity", {scancode, released, extended}, {8'h32, 2'b00});

        kb_or_mouse = 1'b1;
        p0 = pulses;
        frame(8'hF0, 1'b0);
        chk("mouse_f0", {scancode, released, extended}, {8'hF0, 2'b00});
        frame(8'h08, 1'b0);
        chk("mouse_pulses", pulses - p0, 2);
        chk("mouse_08", {scancode, released, extended}, {8'h08, 2'b00});
        kb_or_mouse = 1'b0;

        // Partial frame after an E0 prefix: timeout must abort it and drop the prefix.
        frame(8'hE0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        model_byte(8'h00, 1'b0);
        ps2data_ext = 1'b1;
        tick(600);
        p0 = pulses;
        frame(8'h1C, 1'b0);
        chk("timeout_pulses", pulses - p0, 1);
        chk("timeout_out", {scancode, released, extended}, {8'h1C, 2'b00});

        p0 = pulses;
        ps2data_ext = 1'b0;
        ps2clk_ext = 1'b0;
        tick(2);
        ps2clk_ext = 1'b1;
        tick(5);
        ps2data_ext = 1'b1;
        tick(40);
        frame(8'h4B, 1'b0);
        chk("glitch_pulses", pulses - p0, 1);
        chk("glitch_sc", scancode, 8'h4B);

        // Disabled frame is ignored but a pending F0 survives it.
        frame(8'hF0, 1'b0);
        p0 = pulses;
        enable_rcv = 1'b0;
        send_raw(8'h33, 1'b0);
        enable_rcv = 1'b1;
        tick(10);
        chk("disabled_nopulse", pulses - p0, 0);
        frame(8'h1C, 1'b0);
        chk("pending_kept", {scancode, released, extended}, {8'h1C, 2'b10});

        // Reset in the middle of a frame (clock line high).
        p0 = pulses;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        hold = 10'h000;
        pend_e = 1'b0;
        pend_r = 1'b0;
        exp_q.delete();
        ps2data_ext = 1'b1;
        tick(2);
        chk_en = 1'b1;
        tick(600);
        chk("reset_mid_nopulse", pulses - p0, 0);
        chk("reset_mid_sc", scancode, 8'h00);
        frame(8'h29, 1'b0);
        chk("post_reset_sc", scancode, 8'h29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
